csr_access_unit: RTL and testbench

//  Initiator side of the CSR register-file port. Takes one decoded Zicsr instruction
//  (CSRRW/RS/RC and immediate forms) from execute and runs a read-modify-write on the CSR file.

---
 rtl/csr_pkg.sv | 49 ++++
 rtl/csr_alu.sv | 27 ++
 rtl/csr_access_unit.sv | 155 +++++++++++++++
 tb/tb_csr_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared Zicsr codes, CSR addresses, FSM states and decode helpers
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_t;

    typedef struct packed {
        logic illegal;
        logic read_needed;
        logic rd_we;
    } csr_flags_t;

    // Set/clear with x0 (or zimm 0) must not write, so read-only CSRs stay readable that way
    function automatic logic csr_write_needed(input logic [2:0] funct3, input logic [4:0] rs1_idx);
        case (funct3)
            CSRRW, CSRRWI:                 return 1'b1;
            CSRRS, CSRRC, CSRRSI, CSRRCI:  return rs1_idx != 5'd0;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic csr_flags_t csr_decode(input logic [2:0] funct3, input logic [4:0] rs1_idx,
                                              input logic [4:0] rd_idx, input logic [1:0] addr_top);
        csr_flags_t f;
        logic       wn;
        wn            = csr_write_needed(funct3, rs1_idx);
        f.illegal     = (funct3[1:0] == 2'b00) || (wn && addr_top == 2'b11);
        f.read_needed = !f.illegal && !(funct3[1:0] == 2'b01 && rd_idx == 5'd0);
        f.rd_we       = !f.illegal && (rd_idx != 5'd0);
        return f;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// rtl/csr_alu.sv - read-modify-write value computation for one CSR instruction
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] old_value,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_value,
    output logic            write_needed
);

    always_comb begin
        new_value = old_value;
        case (funct3)
            CSRRW, CSRRWI:   new_value = operand;
            CSRRS, CSRRSI:   new_value = old_value | operand;
            CSRRC, CSRRCI:   new_value = old_value & ~operand;
            default:         new_value = old_value;
        endcase
    end

    assign write_needed = csr_write_needed(funct3, rs1_idx);

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - sequences one Zicsr read-modify-write against the CSR file
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_rs1_idx,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rd_idx,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rd_data,
    output logic [4:0]        resp_rd_idx,
    output logic              resp_rd_we,
    output logic              resp_illegal,
    output logic              csr_read,
    output logic              csr_write,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_write_data,
    input  logic [XLEN-1:0]   csr_read_data
);

    csr_state_t        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rs1_idx_q, rs1_idx_d, rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d, old_q, old_d;
    csr_flags_t        flags_q, flags_d;

    logic              req_ready_d, resp_valid_d, resp_rd_we_d, resp_illegal_d;
    logic              csr_read_d, csr_write_d;
    logic [XLEN-1:0]   resp_rd_data_d, csr_write_data_d;
    logic [4:0]        resp_rd_idx_d;
    logic [ADDR_W-1:0] csr_addr_d;

    logic [XLEN-1:0]   operand, alu_old, alu_new;
    logic              alu_write_needed;

    assign operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
    assign alu_old = flags_q.read_needed ? csr_read_data : '0;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3       (funct3_q),
        .rs1_idx      (rs1_idx_q),
        .old_value    (alu_old),
        .operand      (operand),
        .new_value    (alu_new),
        .write_needed (alu_write_needed)
    );

    always_comb begin
        state_d          = state_q;
        funct3_d         = funct3_q;
        rs1_idx_d        = rs1_idx_q;
        rs1_data_d       = rs1_data_q;
        rd_idx_d         = rd_idx_q;
        old_d            = old_q;
        flags_d          = flags_q;
        req_ready_d      = req_ready;
        resp_valid_d     = resp_valid;
        resp_rd_data_d   = resp_rd_data;
        resp_rd_idx_d    = resp_rd_idx;
        resp_rd_we_d     = resp_rd_we;
        resp_illegal_d   = resp_illegal;
        csr_read_d       = 1'b0;
        csr_write_d      = 1'b0;
        csr_addr_d       = csr_addr;
        csr_write_data_d = csr_write_data;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    funct3_d    = req_funct3;
                    rs1_idx_d   = req_rs1_idx;
                    rs1_data_d  = req_rs1_data;
                    rd_idx_d    = req_rd_idx;
                    flags_d     = csr_decode(req_funct3, req_rs1_idx, req_rd_idx,
                                             req_addr[ADDR_W-1 -: 2]);
                    csr_addr_d  = req_addr;
                    csr_read_d  = flags_d.read_needed;
                    req_ready_d = 1'b0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                old_d            = alu_old;
                csr_write_d      = alu_write_needed && !flags_q.illegal;
                csr_write_data_d = alu_new;
                state_d          = ST_WRITE;
            end
            ST_WRITE: begin
                resp_valid_d   = 1'b1;
                resp_rd_data_d = old_q;
                resp_rd_idx_d  = rd_idx_q;
                resp_rd_we_d   = flags_q.rd_we;
                resp_illegal_d = flags_q.illegal;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            funct3_q       <= '0;
            rs1_idx_q      <= '0;
            rs1_data_q     <= '0;
            rd_idx_q       <= '0;
            old_q          <= '0;
            flags_q        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rd_data   <= '0;
            resp_rd_idx    <= '0;
            resp_rd_we     <= 1'b0;
            resp_illegal   <= 1'b0;
            csr_read       <= 1'b0;
            csr_write      <= 1'b0;
            csr_addr       <= '0;
            csr_write_data <= '0;
        end else begin
            state_q        <= state_d;
            funct3_q       <= funct3_d;
            rs1_idx_q      <= rs1_idx_d;
            rs1_data_q     <= rs1_data_d;
            rd_idx_q       <= rd_idx_d;
            old_q          <= old_d;
            flags_q        <= flags_d;
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_rd_data   <= resp_rd_data_d;
            resp_rd_idx    <= resp_rd_idx_d;
            resp_rd_we     <= resp_rd_we_d;
            resp_illegal   <= resp_illegal_d;
            csr_read       <= csr_read_d;
            csr_write      <= csr_write_d;
            csr_addr       <= csr_addr_d;
            csr_write_data <= csr_write_data_d;
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - randomized self-checking bench for csr_access_unit
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd_idx;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd_data;
    logic [4:0]  resp_rd_idx;
    logic        resp_rd_we;
    logic        resp_illegal;
    logic        csr_read;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;

    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [11:0] addr_tab [0:7];

    int n_checks = 0;
    int n_pass   = 0;
    int n_reads  = 0;
    int n_writes = 0;
    int n_overlap = 0;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_rs1_idx    (req_rs1_idx),
        .req_rs1_data   (req_rs1_data),
        .req_rd_idx     (req_rd_idx),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rd_data   (resp_rd_data),
        .resp_rd_idx    (resp_rd_idx),
        .resp_rd_we     (resp_rd_we),
        .resp_illegal   (resp_illegal),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_addr       (csr_addr),
        .csr_write_data (csr_write_data),
        .csr_read_data  (csr_read_data)
    );

    // CSR file stand-in: combinational read, write on the clock edge
    assign csr_read_data = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (csr_write) csr_mem[csr_addr] <= csr_write_data;
        if (csr_read) n_reads <= n_reads + 1;
        if (csr_write) n_writes <= n_writes + 1;
        if (csr_read && csr_write) n_overlap <= n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Caller is at a negedge with the unit idle; returns at a negedge with the unit idle again
    task automatic exec(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] d, input logic [4:0] rd, input int stall);
        logic [31:0] op, old, nv, exp_data;
        logic        legal, wn, rw, exp_read, exp_wr, exp_we;
        int          rd0, wr0;
        op    = f3[2] ? {27'd0, r1} : d;
        old   = ref_mem[a];
        nv    = old;
        legal = 1'b1;
        wn    = 1'b0;
        rw    = 1'b0;
        case (f3)
            3'b001, 3'b101: begin rw = 1'b1; wn = 1'b1; nv = op; end
            3'b010, 3'b110: begin wn = (r1 != 0); nv = old | op; end
            3'b011, 3'b111: begin wn = (r1 != 0); nv = old & ~op; end
            default:        legal = 1'b0;
        endcase
        if (wn && a[11:10] == 2'b11) legal = 1'b0;
        exp_read = legal && !(rw && rd == 0);
        exp_wr   = legal && wn;
        exp_we   = legal && (rd != 0);
        exp_data = exp_read ? old : 32'd0;
        if (exp_wr) ref_mem[a] = nv;

        rd0 = n_reads;
        wr0 = n_writes;
        check("req_ready_idle", req_ready, 1);
        resp_ready   = (stall == 0);
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_addr     = a;
        req_rs1_idx  = r1;
        req_rs1_data = d;
        req_rd_idx   = rd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_funct3   = 3'($urandom);
        req_addr     = 12'($urandom);
        req_rs1_idx  = 5'($urandom);
        req_rs1_data = $urandom;
        req_rd_idx   = 5'($urandom);
        @(negedge clk);
        check("csr_read_T1", csr_read, exp_read);
        check("req_ready_busy", req_ready, 0);
        @(negedge clk);
        check("csr_write_T2", csr_write, exp_wr);
        check("resp_valid_T2", resp_valid, 0);
        @(negedge clk);
        check("resp_valid_T3", resp_valid, 1);
        check("resp_rd_data", resp_rd_data, exp_data);
        check("resp_rd_idx", resp_rd_idx, rd);
        check("resp_rd_we", resp_rd_we, exp_we);
        check("resp_illegal", resp_illegal, !legal);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", resp_valid, 1);
            check("stall_data", resp_rd_data, exp_data);
            check("stall_we_ill", {resp_rd_we, resp_illegal}, {exp_we, !legal});
            check("stall_req_ready", req_ready, 0);
            check("stall_csr_en", {csr_read, csr_write}, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_req_ready", req_ready, 1);
        check("post_resp_valid", resp_valid, 0);
        check("read_pulses", n_reads - rd0, exp_read);
        check("write_pulses", n_writes - wr0, exp_wr);
        check("csr_value", csr_mem[a], ref_mem[a]);
    endtask

    initial begin
        int wr0;
        addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hC00, 12'hC01, 12'hF11, 12'h7C0};
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        for (int i = 2; i < 8; i++) begin
            ref_mem[addr_tab[i]] = $urandom;
            csr_mem[addr_tab[i]] = ref_mem[addr_tab[i]];
        end
        ref_mem[12'h300] = 32'h0000_1800;
        csr_mem[12'h300] = 32'h0000_1800;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 12'd0;
        req_rs1_idx  = 5'd0;
        req_rs1_data = 32'd0;
        req_rd_idx   = 5'd0;
        resp_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_rd_we, resp_illegal}, 0);
        check("rst_csr_en", {csr_read, csr_write}, 0);
        check("rst_csr_addr", csr_addr, 0);
        check("rst_csr_wdata", csr_write_data, 0);
        check("rst_rd_data", resp_rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        exec(3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 0);
        check("mtvec_value", csr_mem[12'h305], 32'h8000_0100);
        exec(3'b010, 12'h300, 5'd9, 32'h0000_0008, 5'd6, 0);
        check("mstatus_set", csr_mem[12'h300], 32'h0000_1808);
        exec(3'b111, 12'h300, 5'd8, 32'h0000_0000, 5'd7, 0);
        check("mstatus_clr", csr_mem[12'h300], 32'h0000_1800);
        exec(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd3, 0);
        exec(3'b001, 12'h341, 5'd4, 32'h1234_5678, 5'd0, 0);
        exec(3'b001, 12'hC00, 5'd4, 32'hAAAA_5555, 5'd2, 0);
        exec(3'b100, 12'h342, 5'd4, 32'h0000_00FF, 5'd2, 0);
        exec(3'b011, 12'h342, 5'd12, 32'h0F0F_0F0F, 5'd9, 5);

        // Reset while the unit sits in READ
        wr0          = n_writes;
        req_valid    = 1'b1;
        req_funct3   = 3'b001;
        req_addr     = 12'h342;
        req_rs1_idx  = 5'd1;
        req_rs1_data = 32'hDEAD_BEEF;
        req_rd_idx   = 5'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_csr_read", csr_read, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle", {req_ready, resp_valid}, 2'b10);
        repeat (3) @(negedge clk);
        check("midrst_no_write", n_writes - wr0, 0);
        check("midrst_value", csr_mem[12'h342], ref_mem[12'h342]);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] r1, rd;
            r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            exec(3'($urandom), addr_tab[$urandom_range(0, 7)], r1, $urandom, rd,
                 int'($urandom_range(0, 2)));
        end

        check("rd_wr_exclusive", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
